// File: rtl/maq_ms_if.sv
// Bus bundle for the minutes/seconds stage of the clock.
// slave  : used by maq_ms (takes buttons, drives tick, hour request, digits, mode)
// master : used by the environment (drives buttons, observes everything else)
//   btn_mode, btn_inc   : asynchronous active-high buttons
//   enable_1hz          : one-cycle tick every TICK_DIV clocks
//   inc_h               : hour-increment request, qualified by enable_1hz
//   sec_lsd/sec_msd     : seconds BCD digits
//   min_lsd/min_msd     : minutes BCD digits
//   mode                : 0=RUN, 1=SET_MIN, 2=SET_HR
interface maq_ms_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       enable_1hz;
  logic       inc_h;
  logic [3:0] sec_lsd;
  logic [2:0] sec_msd;
  logic [3:0] min_lsd;
  logic [2:0] min_msd;
  logic [1:0] mode;

  modport slave (
    input  btn_mode, btn_inc,
    output enable_1hz, inc_h, sec_lsd, sec_msd, min_lsd, min_msd, mode
  );

  modport master (
    output btn_mode, btn_inc,
    input  enable_1hz, inc_h, sec_lsd, sec_msd, min_lsd, min_msd, mode
  );
endinterface

// File: rtl/maq_ms.sv
// Upstream stage of the hours counter: 1 Hz prescaler, BCD seconds/minutes,
// two-button time-set mode and the hour-increment request for the hours block.
// Ports:
//   maqh_clock : system clock, rising edge
//   reset      : asynchronous active-low reset
//   bus        : maq_ms_if.slave (buttons in; tick, inc_h, digits, mode out)
module maq_ms #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic      maqh_clock,
  input  logic      reset,
  maq_ms_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_MIN = 2'd1,
    MODE_SET_HR  = 2'd2
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [1:0]       mode_sync_q, inc_sync_q;
  logic             mode_dly_q, inc_dly_q;
  logic [3:0]       sec_lsd_q, sec_lsd_d, min_lsd_q, min_lsd_d;
  logic [2:0]       sec_msd_q, sec_msd_d, min_msd_q, min_msd_d;
  logic             pend_q, pend_d;

  logic mode_ev_c, inc_ev_c;
  logic run_c, clr_sec_c, min_inc_c, hr_req_c;
  logic sec59_c, min59_c, min_adv_c;

  // Button rising-edge events after the two-flop synchronizers
  assign mode_ev_c = mode_sync_q[1] & ~mode_dly_q;
  assign inc_ev_c  = inc_sync_q[1]  & ~inc_dly_q;

  assign sec59_c = (sec_msd_q == 3'd5) && (sec_lsd_q == 4'd9);
  assign min59_c = (min_msd_q == 3'd5) && (min_lsd_q == 4'd9);

  // Mode state register
  always_ff @(posedge maqh_clock or negedge reset) begin
    if (!reset) mode_q <= MODE_RUN;
    else        mode_q <= mode_d;
  end

  // Mode next-state: each mode button event advances RUN->SET_MIN->SET_HR->RUN
  always_comb begin
    mode_d = mode_q;
    if (mode_ev_c) begin
      case (mode_q)
        MODE_RUN:     mode_d = MODE_SET_MIN;
        MODE_SET_MIN: mode_d = MODE_SET_HR;
        default:      mode_d = MODE_RUN;
      endcase
    end
  end

  // Mode decode; a same-cycle mode event swallows the increment event
  always_comb begin
    run_c     = 1'b0;
    clr_sec_c = 1'b0;
    min_inc_c = 1'b0;
    hr_req_c  = 1'b0;
    case (mode_q)
      MODE_RUN: begin
        run_c     = 1'b1;
        clr_sec_c = mode_ev_c;
      end
      MODE_SET_MIN: min_inc_c = inc_ev_c & ~mode_ev_c;
      MODE_SET_HR:  hr_req_c  = inc_ev_c & ~mode_ev_c;
      default: ;
    endcase
  end

  // Prescaler; the tick is registered so it lands one cycle after CNT_MAX
  always_comb begin
    en_d  = (cnt_q == CNT_MAX);
    cnt_d = en_d ? '0 : cnt_q + CNT_W'(1);
  end

  // Digit and pending-request next state
  always_comb begin
    sec_lsd_d = sec_lsd_q;
    sec_msd_d = sec_msd_q;
    min_lsd_d = min_lsd_q;
    min_msd_d = min_msd_q;
    min_adv_c = min_inc_c | (run_c & en_q & sec59_c);

    if (run_c && en_q) begin
      if (sec_lsd_q == 4'd9) begin
        sec_lsd_d = 4'd0;
        sec_msd_d = (sec_msd_q == 3'd5) ? 3'd0 : sec_msd_q + 3'd1;
      end else begin
        sec_lsd_d = sec_lsd_q + 4'd1;
      end
    end
    if (clr_sec_c) begin
      sec_lsd_d = 4'd0;
      sec_msd_d = 3'd0;
    end

    if (min_adv_c) begin
      if (min_lsd_q == 4'd9) begin
        min_lsd_d = 4'd0;
        min_msd_d = (min_msd_q == 3'd5) ? 3'd0 : min_msd_q + 3'd1;
      end else begin
        min_lsd_d = min_lsd_q + 4'd1;
      end
    end

    // Tick delivers and clears the request; it wins over a coincident press
    if (en_q)          pend_d = 1'b0;
    else if (hr_req_c) pend_d = 1'b1;
    else               pend_d = pend_q;
  end

  // Datapath registers
  always_ff @(posedge maqh_clock or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      en_q        <= 1'b0;
      mode_sync_q <= 2'b00;
      inc_sync_q  <= 2'b00;
      mode_dly_q  <= 1'b0;
      inc_dly_q   <= 1'b0;
      sec_lsd_q   <= 4'd0;
      sec_msd_q   <= 3'd0;
      min_lsd_q   <= 4'd0;
      min_msd_q   <= 3'd0;
      pend_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      mode_sync_q <= {mode_sync_q[0], bus.btn_mode};
      inc_sync_q  <= {inc_sync_q[0], bus.btn_inc};
      mode_dly_q  <= mode_sync_q[1];
      inc_dly_q   <= inc_sync_q[1];
      sec_lsd_q   <= sec_lsd_d;
      sec_msd_q   <= sec_msd_d;
      min_lsd_q   <= min_lsd_d;
      min_msd_q   <= min_msd_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.enable_1hz = en_q;
  assign bus.inc_h      = en_q & ((run_c & sec59_c & min59_c) | pend_q);
  assign bus.sec_lsd    = sec_lsd_q;
  assign bus.sec_msd    = sec_msd_q;
  assign bus.min_lsd    = min_lsd_q;
  assign bus.min_msd    = min_msd_q;
  assign bus.mode       = mode_q;

endmodule
